// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// Build option: SERIAL_ADD_SUB_EN enables the subtract path (see serial_add_ctrl.sv).
package serial_add_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Number of bits needed to count 0..v-1 (at least 1 for v >= 2).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle between a sequencer (master) and serial_add_ctrl (slave).
// i_sub exists only when SERIAL_ADD_SUB_EN is defined.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             i_start;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
`ifdef SERIAL_ADD_SUB_EN
    logic             i_sub;
`endif
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_sum;
    logic             o_carry;

`ifdef SERIAL_ADD_SUB_EN
    modport master (
        output i_start, i_a, i_b, i_sub,
        input  o_busy, o_done, o_sum, o_carry
    );
    modport slave (
        input  i_start, i_a, i_b, i_sub,
        output o_busy, o_done, o_sum, o_carry
    );
`else
    modport master (
        output i_start, i_a, i_b,
        input  o_busy, o_done, o_sum, o_carry
    );
    modport slave (
        input  i_start, i_a, i_b,
        output o_busy, o_done, o_sum, o_carry
    );
`endif
endinterface

// File: rtl/serial_add_ctrl_adder_slice.sv
// One-bit full adder made of two half adders; the only arithmetic in the controller.
module adder_slice (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);
    logic ha0_sum;
    logic ha0_carry;
    logic ha1_carry;

    assign ha0_sum   = a ^ b;
    assign ha0_carry = a & b;
    assign sum       = ha0_sum ^ c_in;
    assign ha1_carry = ha0_sum & c_in;
    assign c_out     = ha0_carry | ha1_carry;
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: walks adder_slice LSB-first over WIDTH cycles.
// Define SERIAL_ADD_SUB_EN to add i_sub (A-B via inverted B and carry-in of 1).
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic            i_clk,
    input  logic            i_rst,
    serial_add_ctrl_if.slave bus
);
    localparam int CW = clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-2:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             sum_bit;
    logic             c_next;
    logic [WIDTH-1:0] shift_v;
    logic [WIDTH-1:0] b_load;
    logic             cin_load;

`ifdef SERIAL_ADD_SUB_EN
    assign b_load   = bus.i_sub ? ~bus.i_b : bus.i_b;
    assign cin_load = bus.i_sub;
`else
    assign b_load   = bus.i_b;
    assign cin_load = 1'b0;
`endif

    adder_slice u_slice (
        .a     (a_q[0]),
        .b     (b_q[0]),
        .c_in  (c_q),
        .sum   (sum_bit),
        .c_out (c_next)
    );

    // New bit enters at the MSB; after the last bit this is the full result.
    assign shift_v = {sum_bit, res_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    state_d = RUN;
                    a_d     = bus.i_a;
                    b_d     = b_load;
                    cnt_d   = '0;
                    c_d     = cin_load;
                end
            end
            RUN: begin
                res_d = shift_v[WIDTH-1:1];
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                c_d   = c_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    sum_d   = shift_v;
                    carry_d = c_next;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.o_busy  = busy_q;
    assign bus.o_done  = done_q;
    assign bus.o_sum   = sum_q;
    assign bus.o_carry = carry_q;
endmodule
